// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 = CPU MEM stage, port 1 = external master.
// Each transaction takes three cycles: IDLE (arbitrate and latch), ACCESS (drive the DM port), RESP (registered ack).
module dm_port_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [3:0]  i_be0,
  input  logic [3:0]  i_be1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_err0,
  output logic        o_err1,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic [3:0]  o_dm_be,
  input  logic [31:0] i_dm_rdata,
  output logic [1:0]  o_dbg_state,     // 0 idle, 1 access, 2 resp
  output logic [3:0]  o_dbg_wait_cnt,
  output logic        o_dbg_rr_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_legal;
  logic        r_id;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_rr_last;
  logic [3:0]  r_wait_cnt;
  logic        r_ack0, r_ack1, r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;

  logic        w_grant1;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_legal;

  function automatic logic f_legal(input logic [3:0] be, input logic [1:0] a);
    case (be)
      4'b1111:                            f_legal = (a == 2'b00);
      4'b1100, 4'b0011:                   f_legal = ~a[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: f_legal = 1'b1;
      default:                            f_legal = 1'b0;
    endcase
  endfunction

  // Handshake: reqN is held high with a stable payload until ackN; ackN is a one-cycle
  // pulse, and a reqN still high once the block is back in IDLE is a new transaction.
  always_comb begin
    w_grant1 = 1'b0;
    if (i_req0 && i_req1) begin
      if (PRIO_MODE == 0) w_grant1 = ~r_rr_last;
      else                w_grant1 = (r_wait_cnt == 4'(MAX_WAIT));
    end else begin
      w_grant1 = i_req1;
    end
  end

  assign w_we    = w_grant1 ? i_we1    : i_we0;
  assign w_addr  = w_grant1 ? i_addr1  : i_addr0;
  assign w_wdata = w_grant1 ? i_wdata1 : i_wdata0;
  assign w_be    = w_grant1 ? i_be1    : i_be0;
  assign w_legal = f_legal(w_be, w_addr[1:0]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_legal    <= 1'b0;
      r_id       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rr_last  <= 1'b1;
      r_wait_cnt <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_be      <= w_be;
            r_legal   <= w_legal;
            r_id      <= w_grant1;
            r_rr_last <= w_grant1;
            // Port 1 losing while requesting only happens when both ask.
            if (w_grant1)
              r_wait_cnt <= '0;
            else if (i_req1 && PRIO_MODE != 0)
              r_wait_cnt <= r_wait_cnt + 4'd1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_id) r_rdata1 <= r_legal ? i_dm_rdata : 32'd0;
          else      r_rdata0 <= r_legal ? i_dm_rdata : 32'd0;
          r_ack0  <= ~r_id;
          r_ack1  <= r_id;
          r_err0  <= ~r_id & ~r_legal;
          r_err1  <= r_id & ~r_legal;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset cancels a pending write immediately.
  assign o_dm_we        = (r_state == S_ACCESS) & r_we & r_legal;
  assign o_dm_addr      = r_addr;
  assign o_dm_wdata     = r_wdata;
  assign o_dm_be        = r_be;
  assign o_ack0         = r_ack0;
  assign o_ack1         = r_ack1;
  assign o_err0         = r_err0;
  assign o_err1         = r_err1;
  assign o_rdata0       = r_rdata0;
  assign o_rdata1       = r_rdata1;
  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;
  assign o_dbg_rr_last  = r_rr_last;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a round-robin instance and a fixed-priority instance (MAX_WAIT=4), each with
// its own memory, checked every cycle against a transaction-level model plus directed literal checks.
module tb_dm_port_arbiter;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        req[2][2], we[2][2];
  logic [31:0] addr[2][2], wdata[2][2];
  logic [3:0]  be[2][2];
  logic        ack[2][2], err[2][2];
  logic [31:0] rdata[2][2];
  logic        dm_we[2];
  logic [31:0] dm_addr[2], dm_wdata[2], dm_rdata[2];
  logic [3:0]  dm_be[2];
  logic [1:0]  dbg_state[2];
  logic [3:0]  dbg_wait[2];
  logic        dbg_rr[2];
  logic [31:0] dmem[2][16];

  assign dm_rdata[0] = dmem[0][dm_addr[0][5:2]];
  assign dm_rdata[1] = dmem[1][dm_addr[1][5:2]];

  dm_port_arbiter #(.PRIO_MODE(0), .MAX_WAIT(MAXW)) u_rr (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req[0][0]), .i_req1(req[0][1]), .i_we0(we[0][0]), .i_we1(we[0][1]),
    .i_addr0(addr[0][0]), .i_addr1(addr[0][1]), .i_wdata0(wdata[0][0]), .i_wdata1(wdata[0][1]),
    .i_be0(be[0][0]), .i_be1(be[0][1]),
    .o_ack0(ack[0][0]), .o_ack1(ack[0][1]), .o_rdata0(rdata[0][0]), .o_rdata1(rdata[0][1]),
    .o_err0(err[0][0]), .o_err1(err[0][1]),
    .o_dm_we(dm_we[0]), .o_dm_addr(dm_addr[0]), .o_dm_wdata(dm_wdata[0]), .o_dm_be(dm_be[0]),
    .i_dm_rdata(dm_rdata[0]),
    .o_dbg_state(dbg_state[0]), .o_dbg_wait_cnt(dbg_wait[0]), .o_dbg_rr_last(dbg_rr[0])
  );

  dm_port_arbiter #(.PRIO_MODE(1), .MAX_WAIT(MAXW)) u_fp (
    .i_clk(clk), .i_reset(reset),
    .i_req0(req[1][0]), .i_req1(req[1][1]), .i_we0(we[1][0]), .i_we1(we[1][1]),
    .i_addr0(addr[1][0]), .i_addr1(addr[1][1]), .i_wdata0(wdata[1][0]), .i_wdata1(wdata[1][1]),
    .i_be0(be[1][0]), .i_be1(be[1][1]),
    .o_ack0(ack[1][0]), .o_ack1(ack[1][1]), .o_rdata0(rdata[1][0]), .o_rdata1(rdata[1][1]),
    .o_err0(err[1][0]), .o_err1(err[1][1]),
    .o_dm_we(dm_we[1]), .o_dm_addr(dm_addr[1]), .o_dm_wdata(dm_wdata[1]), .o_dm_be(dm_be[1]),
    .i_dm_rdata(dm_rdata[1]),
    .o_dbg_state(dbg_state[1]), .o_dbg_wait_cnt(dbg_wait[1]), .o_dbg_rr_last(dbg_rr[1])
  );

  // Transaction-level model: one outstanding grant per instance, timed by edge numbers.
  int          cyc;
  int          n_checks, n_fail;
  bit          pv[2];
  int          pg[2], last_g[2], m_wait[2];
  int          pwin[2];
  bit          pwe[2], plegal[2], m_rr[2];
  logic [31:0] paddr[2], pwdata[2], prdata[2];
  logic [3:0]  pbe[2];
  logic [31:0] mmem[2][16];
  int          log0[$], log1[$], acyc0[$];
  logic [0:0]  exp_q[$];

  function automatic void check(input string name, input int d, input logic [31:0] got,
                                input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h expected=%h", name, d, cyc, got, exp);
    end
  endfunction

  function automatic bit m_legal(input logic [3:0] b, input logic [31:0] a);
    if (b == 4'hF) return (a % 4) == 0;
    if (b == 4'hC || b == 4'h3) return (a % 2) == 0;
    return $countones(b) == 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pv[d] = 0; last_g[d] = -100; m_rr[d] = 1; m_wait[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pbe[d] = '0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int d = 0; d < 2; d++) begin
      if (!reset && (cyc + 1 >= last_g[d] + 3) && (req[d][0] || req[d][1])) begin
        if (req[d][0] && req[d][1]) begin
          if (d == 0) w = m_rr[d] ? 0 : 1;
          else if (m_wait[d] == MAXW) w = 1;
          else begin w = 0; m_wait[d]++; end
        end else begin
          w = req[d][1] ? 1 : 0;
        end
        if (w == 1) m_wait[d] = 0;
        m_rr[d] = (w == 1);
        last_g[d] = cyc + 1; pv[d] = 1; pg[d] = cyc + 1; pwin[d] = w;
        pwe[d] = we[d][w]; paddr[d] = addr[d][w]; pwdata[d] = wdata[d][w]; pbe[d] = be[d][w];
        plegal[d] = m_legal(pbe[d], paddr[d]);
        prdata[d] = plegal[d] ? mmem[d][paddr[d][5:2]] : 32'd0;
      end
    end
  endtask

  task automatic compare();
    int st;
    bit ea;
    for (int d = 0; d < 2; d++) begin
      if (pv[d] && cyc == pg[d] + 1 && pwe[d] && plegal[d])
        for (int i = 0; i < 4; i++)
          if (pbe[d][i]) mmem[d][paddr[d][5:2]][8*i +: 8] = pwdata[d][8*i +: 8];
      st = (pv[d] && cyc == pg[d]) ? 1 : ((pv[d] && cyc == pg[d] + 1) ? 2 : 0);
      check("state", d, 32'(dbg_state[d]), 32'(st));
      check("dm_we", d, 32'(dm_we[d]), 32'(st == 1 && pwe[d] && plegal[d]));
      check("dm_addr", d, dm_addr[d], paddr[d]);
      check("dm_wdata", d, dm_wdata[d], pwdata[d]);
      check("dm_be", d, 32'(dm_be[d]), 32'(pbe[d]));
      check("wait_cnt", d, 32'(dbg_wait[d]), 32'(m_wait[d]));
      check("rr_last", d, 32'(dbg_rr[d]), 32'(m_rr[d]));
      for (int p = 0; p < 2; p++) begin
        ea = (st == 2) && (pwin[d] == p);
        check(p == 0 ? "ack0" : "ack1", d, 32'(ack[d][p]), 32'(ea));
        check(p == 0 ? "err0" : "err1", d, 32'(err[d][p]), 32'(ea && !plegal[d]));
        if (ea) check(p == 0 ? "rdata0" : "rdata1", d, rdata[d][p], prdata[d]);
        if (ack[d][p]) begin
          if (d == 0) begin log0.push_back(p); acyc0.push_back(cyc); end
          else log1.push_back(p);
        end
      end
      if (st == 2) pv[d] = 0;
    end
  endtask

  // The memory commits captured write strobes after the edge, so the DUT never races its own write.
  task automatic advance();
    logic        cw[2];
    logic [31:0] ca[2], cd[2];
    logic [3:0]  cb[2];
    model_step();
    for (int d = 0; d < 2; d++) begin
      cw[d] = dm_we[d]; ca[d] = dm_addr[d]; cd[d] = dm_wdata[d]; cb[d] = dm_be[d];
    end
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++)
      if (cw[d])
        for (int i = 0; i < 4; i++)
          if (cb[d][i]) dmem[d][ca[d][5:2]][8*i +: 8] = cd[d][8*i +: 8];
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    advance();
    advance();
    reset = 1'b0;
    log0.delete(); log1.delete(); acyc0.delete();
  endtask

  task automatic do_txn(input int d, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        output logic [31:0] rd, output logic er, output int lat);
    int s;
    s = cyc; lat = -1; rd = '0; er = 1'b0;
    req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd; be[d][p] = b;
    for (int k = 0; k < 12; k++) begin
      advance();
      if (ack[d][p]) begin
        lat = cyc - s; rd = rdata[d][p]; er = err[d][p];
        break;
      end
    end
    req[d][p] = 1'b0;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout dut=%0d port=%0d got=no_ack expected=ack", d, p);
    end
  endtask

  task automatic new_payload(input int d, input int p);
    logic [3:0] legal_be[7];
    legal_be = '{4'hF, 4'hC, 4'h3, 4'h1, 4'h2, 4'h4, 4'h8};
    we[d][p]    = 1'($urandom_range(0, 1));
    addr[d][p]  = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 2) != 0) addr[d][p][1:0] = 2'b00;
    wdata[d][p] = $urandom;
    if ($urandom_range(0, 4) == 0) be[d][p] = 4'($urandom_range(0, 15));
    else be[d][p] = legal_be[$urandom_range(0, 6)];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, saved;
    logic        er;
    int          lat;
    n_checks = 0; n_fail = 0; cyc = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        dmem[d][w] = $urandom; mmem[d][w] = dmem[d][w];
      end
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 0; we[d][p] = 0; addr[d][p] = '0; wdata[d][p] = '0; be[d][p] = '0;
      end
    end
    dmem[0][12] = 32'h11223344; mmem[0][12] = 32'h11223344;
    do_reset();
    check("reset_rr_last", 0, 32'(dbg_rr[0]), 32'd1);
    check("reset_rdata0", 0, rdata[0][0], 32'd0);
    check("reset_dm_addr", 1, dm_addr[1], 32'd0);

    // Word write then read-back; first ack two cycles after the request.
    do_txn(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr_latency", 0, 32'(lat), 32'd2);
    do_txn(0, 0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("rd_data", 0, rd, 32'hDEADBEEF);
    check("rd_err", 0, 32'(er), 32'd0);

    // Misaligned word write from port 1 is rejected and leaves memory alone.
    saved = dmem[0][8];
    do_txn(0, 1, 1'b1, 32'h22, 32'h55667788, 4'hF, rd, er, lat);
    check("mis_err", 0, 32'(er), 32'd1);
    check("mis_rdata", 0, rd, 32'd0);
    check("mis_mem", 0, dmem[0][8], saved);

    // Single-byte write returns the old word and merges one lane.
    do_txn(0, 0, 1'b1, 32'h30, 32'h00AA0000, 4'b0100, rd, er, lat);
    check("byte_rdata", 0, rd, 32'h11223344);
    check("byte_mem", 0, dmem[0][12], 32'h11AA3344);

    // Reset during ACCESS of a write.
    saved = dmem[0][14];
    req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 32'h38; wdata[0][0] = 32'hCAFEF00D; be[0][0] = 4'hF;
    for (int k = 0; k < 6 && dbg_state[0] != 2'd1; k++) advance();
    check("pre_reset_we", 0, 32'(dm_we[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_we", 0, 32'(dm_we[0]), 32'd0);
    check("abort_state", 0, 32'(dbg_state[0]), 32'd0);
    model_reset();
    req[0][0] = 1'b0;
    advance();
    advance();
    check("abort_mem", 0, dmem[0][14], saved);
    reset = 1'b0;

    // Round-robin with both ports held from reset.
    for (int p = 0; p < 2; p++) begin
      req[0][p] = 1'b1; we[0][p] = 1'b0; addr[0][p] = 32'(4 * (p + 1)); be[0][p] = 4'hF;
    end
    do_reset();
    for (int k = 0; k < 30 && log0.size() < 4; k++) advance();
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    check("rr_count", 0, 32'(log0.size()), 32'd4);
    for (int i = 0; i < 4 && i < log0.size(); i++) check("rr_grant", 0, 32'(log0[i]), 32'(exp_q[i]));
    for (int i = 1; i < 4 && i < acyc0.size(); i++) check("rr_spacing", 0, 32'(acyc0[i] - acyc0[i-1]), 32'd3);
    for (int k = 0; k < 3; k++) advance();

    // Fixed priority with anti-starvation.
    for (int p = 0; p < 2; p++) begin
      req[1][p] = 1'b1; we[1][p] = 1'b0; addr[1][p] = 32'(8 * (p + 1)); be[1][p] = 4'hF;
    end
    do_reset();
    for (int k = 0; k < 60 && log1.size() < 10; k++) advance();
    check("fp_wait_cleared", 1, 32'(dbg_wait[1]), 32'd0);
    req[1][0] = 1'b0; req[1][1] = 1'b0;
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check("fp_count", 1, 32'(log1.size()), 32'd10);
    for (int i = 0; i < 10 && i < log1.size(); i++) check("fp_grant", 1, 32'(log1[i]), 32'(exp_q[i]));
    for (int k = 0; k < 3; k++) advance();

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      advance();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          if (req[d][p] && ack[d][p]) begin
            if ($urandom_range(0, 1) == 0) req[d][p] = 1'b0;
            else new_payload(d, p);
          end else if (!req[d][p] && $urandom_range(0, 3) == 0) begin
            req[d][p] = 1'b1;
            new_payload(d, p);
          end
        end
    end
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) req[d][p] = 1'b0;
    for (int k = 0; k < 4; k++) advance();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) check("mem_final", d, dmem[d][w], mmem[d][w]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
